// File: rtl/seq_mant_normalizer_if.sv
// Handshake bundle for the iterative mantissa normalizer: operand side
// (in_*) and result side (out_*). The normalizer itself uses the slave view.
interface seq_mant_normalizer_if #(
    parameter int MANT_W  = 8,
    parameter int EXP_W   = 8,
    parameter int SHIFT_W = 3
);
    logic               in_valid;
    logic               in_ready;
    logic               in_sign;
    logic [MANT_W-1:0]  in_mant;
    logic [EXP_W-1:0]   in_exp;

    logic               out_valid;
    logic               out_ready;
    logic               out_sign;
    logic [MANT_W-1:0]  out_mant;
    logic [EXP_W-1:0]   out_exp;
    logic [SHIFT_W-1:0] out_shift;
    logic               out_zero;
    logic               out_denorm;

    modport slave (
        input  in_valid, in_sign, in_mant, in_exp, out_ready,
        output in_ready, out_valid, out_sign, out_mant, out_exp,
               out_shift, out_zero, out_denorm
    );

    modport master (
        output in_valid, in_sign, in_mant, in_exp, out_ready,
        input  in_ready, out_valid, out_sign, out_mant, out_exp,
               out_shift, out_zero, out_denorm
    );
endinterface

// File: rtl/seq_mant_normalizer.sv
// Iterative left-normalizer: shifts the mantissa left one bit per clock,
// decrementing the exponent, until the hidden-one position is set or the
// exponent bottoms out at zero (denormal). One operand in flight at a time.
// The working registers double as the result registers, so the outputs are
// only meaningful while out_valid is high and simply hold afterwards.
module seq_mant_normalizer #(
    parameter int MANT_W  = 8,
    parameter int EXP_W   = 8,
    parameter int SHIFT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_mant_normalizer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state;
    logic                 valid_r;
    logic                 sign_r;
    logic [MANT_W-1:0]    mant_r;
    logic [EXP_W-1:0]     exp_r;
    logic [SHIFT_W-1:0]   shift_r;
    logic                 zero_r;
    logic                 denorm_r;
    logic                 in_ready_w;

    // Exponent decrement that floors at zero instead of wrapping.
    function automatic logic [EXP_W-1:0] exp_dec_sat(input logic [EXP_W-1:0] e);
        return (e == '0) ? '0 : e - 1'b1;
    endfunction

    // Ready only while idle and out of reset; never looks at in_valid.
    assign in_ready_w = (state == IDLE) && rst_n;

    // Control FSM and working registers: capture, shift loop, result hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            valid_r  <= 1'b0;
            sign_r   <= 1'b0;
            mant_r   <= '0;
            exp_r    <= '0;
            shift_r  <= '0;
            zero_r   <= 1'b0;
            denorm_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_w) begin
                        sign_r   <= bus.in_sign;
                        shift_r  <= '0;
                        denorm_r <= 1'b0;
                        if (bus.in_mant == '0) begin
                            // Zero has no leading one to find: finish at once.
                            mant_r  <= '0;
                            exp_r   <= '0;
                            zero_r  <= 1'b1;
                            valid_r <= 1'b1;
                            state   <= DONE;
                        end else begin
                            mant_r <= bus.in_mant;
                            exp_r  <= bus.in_exp;
                            zero_r <= 1'b0;
                            state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (mant_r[MANT_W-1]) begin
                        valid_r <= 1'b1;
                        state   <= DONE;
                    end else if (exp_r == '0) begin
                        // Exponent exhausted before the hidden one appeared.
                        denorm_r <= 1'b1;
                        valid_r  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        mant_r  <= mant_r << 1;
                        exp_r   <= exp_dec_sat(exp_r);
                        shift_r <= shift_r + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        valid_r <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = valid_r;
    assign bus.out_sign   = sign_r;
    assign bus.out_mant   = mant_r;
    assign bus.out_exp    = exp_r;
    assign bus.out_shift  = shift_r;
    assign bus.out_zero   = zero_r;
    assign bus.out_denorm = denorm_r;

endmodule
